// File: rtl/cgra_pkg.sv
// Shared state encoding, sizing helper and default timing constants for the
// CGRA kernel sequencer.
package cgra_pkg;

    localparam int STATE_W       = 3;
    localparam int DEF_TIMEOUT   = 1024;
    localparam int DEF_DRAIN_CYC = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_RUN       = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    function automatic int clog2(input int value);
        int remaining;
        int result;
        remaining = value - 32'sd1;
        result    = 32'sd0;
        while (remaining > 32'sd0) begin
            result    = result + 32'sd1;
            remaining = remaining >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cgra_chan_agu.sv
// Per-channel address generator: keeps the running base for the current
// iteration and forms the BRAM byte address and byte enables during a run.
module cgra_chan_agu
    import cgra_pkg::*;
#(
    parameter int SYS_DWIDTH = 32,
    parameter int BYTE_LEN   = 4
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic                  run,
    input  logic                  store_en,
    input  logic [SYS_DWIDTH-1:0] load_base,
    input  logic [SYS_DWIDTH-1:0] stride,
    input  logic [SYS_DWIDTH-1:0] word_cnt,
    output logic [SYS_DWIDTH-1:0] addr,
    output logic [BYTE_LEN-1:0]   wen
);

    localparam int BYTE_SHIFT = clog2(BYTE_LEN);

    logic [SYS_DWIDTH-1:0] cur_base_r;

    // Running base: loaded at batch start, advanced by the stride between iterations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_base_r <= {SYS_DWIDTH{1'b0}};
        end else if (load) begin
            cur_base_r <= load_base;
        end else if (step) begin
            cur_base_r <= cur_base_r + stride;
        end else begin
            cur_base_r <= cur_base_r;
        end
    end

    // Address and byte enables are driven only while the array is running.
    always_comb begin
        addr = {SYS_DWIDTH{1'b0}};
        wen  = {BYTE_LEN{1'b0}};
        if (run) begin
            addr = cur_base_r + (word_cnt << BYTE_SHIFT);
            wen  = {BYTE_LEN{store_en}};
        end else begin
            addr = {SYS_DWIDTH{1'b0}};
            wen  = {BYTE_LEN{1'b0}};
        end
    end

endmodule

// File: rtl/cgra_kernel_seq.sv
// Kernel sequencer between the PE array and its BRAM channels: launches
// Cfg_Iter back-to-back kernel runs with strided bases and a busy timeout.
module cgra_kernel_seq
    import cgra_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int SYS_DWIDTH = 32,
    parameter int BYTE_LEN   = 4,
    parameter int ITER_W     = 16,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int DRAIN_CYC  = DEF_DRAIN_CYC
)
(
    input  logic                           Clk,
    input  logic                           Resetn,
    output logic [NUM_CH-1:0]              Port_Clk,
    output logic [NUM_CH-1:0]              Port_Rst,
    output logic [NUM_CH-1:0]              Port_En,
    output logic [NUM_CH*BYTE_LEN-1:0]     Port_Wen,
    output logic [NUM_CH*SYS_DWIDTH-1:0]   Port_Addr,
    output logic [NUM_CH*SYS_DWIDTH-1:0]   Port_Data_To_Bram,
    input  logic [NUM_CH*SYS_DWIDTH-1:0]   Port_Data_From_Bram,
    output logic [NUM_CH*SYS_DWIDTH-1:0]   Array_Load_Data,
    input  logic [NUM_CH*SYS_DWIDTH-1:0]   Array_Store_Data,
    input  logic [NUM_CH-1:0]              Array_Store_En,
    output logic                           Array_Start,
    input  logic                           Array_Busy,
    input  logic [NUM_CH*SYS_DWIDTH-1:0]   Cfg_Base,
    input  logic [SYS_DWIDTH-1:0]          Cfg_Stride,
    input  logic [ITER_W-1:0]              Cfg_Iter,
    input  logic                           Computation_Start,
    output logic                           Computation_Done,
    output logic                           Error,
    output logic [ITER_W-1:0]              Iter_Cnt
);

    localparam int TO_W = (clog2(TIMEOUT) > 0) ? clog2(TIMEOUT) : 1;
    localparam int DR_W = (clog2(DRAIN_CYC) > 0) ? clog2(DRAIN_CYC) : 1;
    localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [DR_W-1:0]       DR_LAST  = DR_W'(DRAIN_CYC - 1);
    localparam logic [TO_W-1:0]       TO_ONE   = TO_W'(1'b1);
    localparam logic [DR_W-1:0]       DR_ONE   = DR_W'(1'b1);
    localparam logic [SYS_DWIDTH-1:0] WORD_ONE = SYS_DWIDTH'(1'b1);
    localparam logic [ITER_W-1:0]     ITER_ONE = ITER_W'(1'b1);

    state_e                state_r;
    state_e                state_s;
    logic                  start_prev_r;
    logic                  start_edge_s;
    logic                  capture_s;
    logic                  step_s;
    logic                  set_err_s;
    logic                  iter_inc_s;
    logic [ITER_W-1:0]     iter_next_s;
    logic [ITER_W-1:0]     iter_cfg_r;
    logic [ITER_W-1:0]     iter_cnt_r;
    logic [SYS_DWIDTH-1:0] stride_r;
    logic [SYS_DWIDTH-1:0] word_cnt_r;
    logic [TO_W-1:0]       to_cnt_r;
    logic [DR_W-1:0]       drain_cnt_r;
    logic                  start_r;
    logic                  run_r;
    logic                  done_r;
    logic                  error_r;

    assign start_edge_s = Computation_Start & ~start_prev_r;
    assign iter_next_s  = iter_cnt_r + ITER_ONE;

    // Next-state logic and the one-cycle control strobes for the datapath.
    always_comb begin
        state_s    = state_r;
        capture_s  = 1'b0;
        step_s     = 1'b0;
        set_err_s  = 1'b0;
        iter_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_edge_s) begin
                    capture_s = 1'b1;
                    if (Cfg_Iter != {ITER_W{1'b0}}) begin
                        state_s = ST_ARM;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                state_s = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // Busy wins over the timeout when both land on the same cycle.
                if (Array_Busy) begin
                    state_s = ST_RUN;
                end else if (to_cnt_r == TO_LAST) begin
                    set_err_s = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    state_s = ST_WAIT_BUSY;
                end
            end
            ST_RUN: begin
                if (!Array_Busy) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DR_LAST) begin
                    iter_inc_s = 1'b1;
                    if (iter_next_s < iter_cfg_r) begin
                        step_s  = 1'b1;
                        state_s = ST_ARM;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (!Computation_Start) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register, start-edge history and registered output strobes.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_r      <= ST_IDLE;
            start_prev_r <= 1'b0;
            start_r      <= 1'b0;
            run_r        <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            start_prev_r <= Computation_Start;
            start_r      <= (state_s == ST_ARM);
            run_r        <= (state_s == ST_RUN);
            done_r       <= (state_s == ST_DONE);
        end
    end

    // Batch shadow registers, completed-iteration count and sticky error.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            iter_cfg_r <= {ITER_W{1'b0}};
            stride_r   <= {SYS_DWIDTH{1'b0}};
            iter_cnt_r <= {ITER_W{1'b0}};
            error_r    <= 1'b0;
        end else if (capture_s) begin
            iter_cfg_r <= Cfg_Iter;
            stride_r   <= Cfg_Stride;
            iter_cnt_r <= {ITER_W{1'b0}};
            error_r    <= 1'b0;
        end else begin
            if (iter_inc_s) begin
                iter_cnt_r <= iter_next_s;
            end else begin
                iter_cnt_r <= iter_cnt_r;
            end
            if (set_err_s) begin
                error_r <= 1'b1;
            end else begin
                error_r <= error_r;
            end
        end
    end

    // Word, timeout and drain counters; the latter two rest at zero outside their states.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            word_cnt_r  <= {SYS_DWIDTH{1'b0}};
            to_cnt_r    <= {TO_W{1'b0}};
            drain_cnt_r <= {DR_W{1'b0}};
        end else begin
            if (capture_s || step_s) begin
                word_cnt_r <= {SYS_DWIDTH{1'b0}};
            end else if (state_r == ST_RUN) begin
                word_cnt_r <= word_cnt_r + WORD_ONE;
            end else begin
                word_cnt_r <= word_cnt_r;
            end
            if (state_r == ST_WAIT_BUSY) begin
                to_cnt_r <= to_cnt_r + TO_ONE;
            end else begin
                to_cnt_r <= {TO_W{1'b0}};
            end
            if (state_r == ST_DRAIN) begin
                drain_cnt_r <= drain_cnt_r + DR_ONE;
            end else begin
                drain_cnt_r <= {DR_W{1'b0}};
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        cgra_chan_agu #(
            .SYS_DWIDTH (SYS_DWIDTH),
            .BYTE_LEN   (BYTE_LEN)
        ) u_agu (
            .clk       (Clk),
            .rst_n     (Resetn),
            .load      (capture_s),
            .step      (step_s),
            .run       (run_r),
            .store_en  (Array_Store_En[c]),
            .load_base (Cfg_Base[c*SYS_DWIDTH +: SYS_DWIDTH]),
            .stride    (stride_r),
            .word_cnt  (word_cnt_r),
            .addr      (Port_Addr[c*SYS_DWIDTH +: SYS_DWIDTH]),
            .wen       (Port_Wen[c*BYTE_LEN +: BYTE_LEN])
        );
    end

    assign Port_Clk          = {NUM_CH{Clk}};
    assign Port_Rst          = {NUM_CH{~Resetn}};
    assign Port_En           = {NUM_CH{run_r}};
    assign Port_Data_To_Bram = Array_Store_Data;
    assign Array_Load_Data   = Port_Data_From_Bram;
    assign Array_Start       = start_r;
    assign Computation_Done  = done_r;
    assign Error             = error_r;
    assign Iter_Cnt          = iter_cnt_r;

endmodule

// File: tb/tb_cgra_kernel_seq.sv
// Bench for cgra_kernel_seq: each batch is planned up front as a cycle timeline
// derived from the sequencing rules, then driven and compared every cycle.
module tb_cgra_kernel_seq;

    localparam int NCH = 2;
    localparam int DW  = 32;
    localparam int BL  = 4;
    localparam int IW  = 16;
    localparam int TMO = 16;
    localparam int DRN = 2;

    logic              Clk = 1'b0;
    logic              Resetn;
    logic [NCH-1:0]    Port_Clk, Port_Rst, Port_En;
    logic [NCH*BL-1:0] Port_Wen;
    logic [NCH*DW-1:0] Port_Addr, Port_Data_To_Bram, Port_Data_From_Bram;
    logic [NCH*DW-1:0] Array_Load_Data, Array_Store_Data, Cfg_Base;
    logic [NCH-1:0]    Array_Store_En;
    logic              Array_Start, Array_Busy, Computation_Start, Computation_Done, Error;
    logic [DW-1:0]     Cfg_Stride;
    logic [IW-1:0]     Cfg_Iter, Iter_Cnt;

    cgra_kernel_seq #(
        .NUM_CH(NCH), .SYS_DWIDTH(DW), .BYTE_LEN(BL), .ITER_W(IW),
        .TIMEOUT(TMO), .DRAIN_CYC(DRN)
    ) dut (
        .Clk(Clk), .Resetn(Resetn), .Port_Clk(Port_Clk), .Port_Rst(Port_Rst),
        .Port_En(Port_En), .Port_Wen(Port_Wen), .Port_Addr(Port_Addr),
        .Port_Data_To_Bram(Port_Data_To_Bram), .Port_Data_From_Bram(Port_Data_From_Bram),
        .Array_Load_Data(Array_Load_Data), .Array_Store_Data(Array_Store_Data),
        .Array_Store_En(Array_Store_En), .Array_Start(Array_Start), .Array_Busy(Array_Busy),
        .Cfg_Base(Cfg_Base), .Cfg_Stride(Cfg_Stride), .Cfg_Iter(Cfg_Iter),
        .Computation_Start(Computation_Start), .Computation_Done(Computation_Done),
        .Error(Error), .Iter_Cnt(Iter_Cnt)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int prev_iter;
    bit prev_err;

    // Planned timeline of one batch, indexed by cycle relative to its start.
    bit          t_start [0:511];
    bit          t_en    [0:511];
    bit          t_busy  [0:511];
    bit          t_done  [0:511];
    bit          t_err   [0:511];
    int          t_iter  [0:511];
    logic [31:0] t_a0    [0:511];
    logic [31:0] t_a1    [0:511];

    int plan_d  [0:7];
    int plan_l  [0:7];
    bit plan_to [0:7];

    logic [31:0] obs_a0[$];
    logic [31:0] obs_a1[$];
    logic [31:0] obs_first[$];
    int          obs_st[$];
    int          done_first;
    int          done_cnt;
    bit          prev_en;

    task automatic chk(input string name, input int cyc, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_plan();
        for (int j = 0; j < 8; j++) begin
            plan_d[j]  = 0;
            plan_l[j]  = 1;
            plan_to[j] = 1'b0;
        end
    endtask

    task automatic compare_cycle(input int k);
        logic [7:0] w;
        w = t_en[k] ? {{4{Array_Store_En[1]}}, {4{Array_Store_En[0]}}} : 8'h00;
        chk("array_start", k, 64'(Array_Start), 64'(t_start[k]));
        chk("port_en", k, 64'(Port_En), 64'({2{t_en[k]}}));
        chk("port_addr", k, Port_Addr, {t_a1[k], t_a0[k]});
        chk("port_wen", k, 64'(Port_Wen), 64'(w));
        chk("done", k, 64'(Computation_Done), 64'(t_done[k]));
        chk("error", k, 64'(Error), 64'(t_err[k]));
        chk("iter_cnt", k, 64'(Iter_Cnt), 64'(t_iter[k]));
        chk("load_data", k, Array_Load_Data, Port_Data_From_Bram);
        chk("store_data", k, Port_Data_To_Bram, Array_Store_Data);
        chk("port_rst", k, 64'(Port_Rst), 64'(2'b00));
        chk("port_clk", k, 64'(Port_Clk), 64'(2'b00));
        if (Port_En[0]) begin
            obs_a0.push_back(Port_Addr[31:0]);
            obs_a1.push_back(Port_Addr[63:32]);
            if (!prev_en) obs_first.push_back(Port_Addr[31:0]);
        end
        if (Array_Start) obs_st.push_back(k);
        if (Computation_Done) begin
            done_cnt++;
            if (done_first < 0) done_first = k;
        end
        prev_en = Port_En[0];
    endtask

    task automatic run_batch(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] st,
                             input int n, input int gap, input int drop_rel);
        int a, e, drop, last, cnt;
        bit to_hit;
        int comp[$];
        for (int k = 0; k < 512; k++) begin
            t_start[k] = 1'b0; t_en[k] = 1'b0; t_busy[k] = 1'b0; t_done[k] = 1'b0;
            t_a0[k] = 32'h0; t_a1[k] = 32'h0;
        end
        a = gap + 1;
        e = gap + 1;
        to_hit = 1'b0;
        for (int j = 0; j < n; j++) begin
            t_start[a] = 1'b1;
            if (plan_to[j]) begin
                e = a + 1 + TMO;
                to_hit = 1'b1;
                break;
            end
            for (int i = 0; i < plan_l[j]; i++) begin
                t_busy[a + 1 + plan_d[j] + i] = 1'b1;
                t_en[a + 2 + plan_d[j] + i]   = 1'b1;
                t_a0[a + 2 + plan_d[j] + i]   = b0 + st * 32'(j) + 32'(4 * i);
                t_a1[a + 2 + plan_d[j] + i]   = b1 + st * 32'(j) + 32'(4 * i);
            end
            a = a + 2 + plan_d[j] + plan_l[j] + DRN;
            comp.push_back(a);
            e = a;
        end
        drop = e + drop_rel;
        if (drop < gap + 1) drop = gap + 1;
        last = (drop > e) ? drop : e;
        for (int k = 0; k <= last; k++) begin
            t_done[k] = (k >= e);
            if (k <= gap) begin
                t_err[k]  = prev_err;
                t_iter[k] = prev_iter;
            end else begin
                t_err[k] = to_hit && (k >= e);
                cnt = 0;
                foreach (comp[q]) if (comp[q] <= k) cnt++;
                t_iter[k] = cnt;
            end
        end
        obs_a0.delete(); obs_a1.delete(); obs_first.delete(); obs_st.delete();
        done_first = -1;
        done_cnt   = 0;
        prev_en    = 1'b0;
        for (int k = 0; k <= last; k++) begin
            @(posedge Clk);
            #1;
            Computation_Start   = (k >= gap) && (k < drop);
            Array_Busy          = t_busy[k];
            Array_Store_En      = 2'($urandom_range(0, 3));
            Array_Store_Data    = {$urandom, $urandom};
            Port_Data_From_Bram = {$urandom, $urandom};
            if (k == gap) begin
                Cfg_Base   = {b1, b0};
                Cfg_Stride = st;
                Cfg_Iter   = 16'(n);
            end else begin
                Cfg_Base   = {$urandom, $urandom};
                Cfg_Stride = $urandom;
                Cfg_Iter   = 16'($urandom);
            end
            @(negedge Clk);
            compare_cycle(k);
        end
        prev_iter = comp.size();
        prev_err  = to_hit;
    endtask

    initial begin
        Resetn = 1'b0;
        Computation_Start = 1'b0; Array_Busy = 1'b0; Array_Store_En = 2'b00;
        Array_Store_Data = 64'h0; Port_Data_From_Bram = 64'h0;
        Cfg_Base = 64'h0; Cfg_Stride = 32'h0; Cfg_Iter = 16'h0;
        prev_iter = 0; prev_err = 1'b0;

        repeat (2) @(posedge Clk);
        #1;
        chk("reset_port_clk_hi", -1, 64'(Port_Clk), 64'(2'b11));
        chk("reset_port_rst", -1, 64'(Port_Rst), 64'(2'b11));
        chk("reset_outputs", -1, {Port_Addr[31:0], 8'(Port_Wen), 2'(Port_En), Array_Start,
                                  Computation_Done, Error, 16'(Iter_Cnt)}, 64'h0);
        @(negedge Clk);
        Resetn = 1'b1;

        // Single iteration, four-cycle run.
        clear_plan();
        plan_d[0] = 1; plan_l[0] = 4;
        run_batch(32'h100, 32'h200, 32'h40, 1, 2, 3);
        chk("t1_nwords", -1, 64'(obs_a0.size()), 64'd4);
        chk("t1_a0_0", -1, 64'(obs_a0[0]), 64'h100);
        chk("t1_a0_1", -1, 64'(obs_a0[1]), 64'h104);
        chk("t1_a0_2", -1, 64'(obs_a0[2]), 64'h108);
        chk("t1_a0_3", -1, 64'(obs_a0[3]), 64'h10C);
        chk("t1_a1_0", -1, 64'(obs_a1[0]), 64'h200);
        chk("t1_a1_3", -1, 64'(obs_a1[3]), 64'h20C);
        chk("t1_iter", -1, 64'(Iter_Cnt), 64'd1);
        chk("t1_done_len", -1, 64'(done_cnt), 64'd4);

        // Three strided iterations.
        clear_plan();
        for (int j = 0; j < 3; j++) begin plan_d[j] = 2; plan_l[j] = 3; end
        run_batch(32'h100, 32'h200, 32'h40, 3, 1, 0);
        chk("t2_starts", -1, 64'(obs_st.size()), 64'd3);
        chk("t2_first0", -1, 64'(obs_first[0]), 64'h100);
        chk("t2_first1", -1, 64'(obs_first[1]), 64'h140);
        chk("t2_first2", -1, 64'(obs_first[2]), 64'h180);
        chk("t2_iter", -1, 64'(Iter_Cnt), 64'd3);

        // Busy never rises.
        clear_plan();
        plan_to[0] = 1'b1;
        run_batch(32'h100, 32'h200, 32'h40, 1, 2, -2);
        chk("t3_error", -1, 64'(Error), 64'd1);
        chk("t3_starts", -1, 64'(obs_st.size()), 64'd1);
        chk("t3_latency", -1, 64'(done_first - obs_st[0]), 64'd17);
        chk("t3_no_en", -1, 64'(obs_a0.size()), 64'd0);
        chk("t3_done_len", -1, 64'(done_cnt), 64'd1);

        // Zero iterations.
        clear_plan();
        run_batch(32'h100, 32'h200, 32'h40, 0, 3, 0);
        chk("t4_starts", -1, 64'(obs_st.size()), 64'd0);
        chk("t4_done_at", -1, 64'(done_first), 64'd4);
        chk("t4_done_len", -1, 64'(done_cnt), 64'd1);
        chk("t4_error_cleared", -1, 64'(Error), 64'd0);

        // Address wrap, with Busy arriving on the last cycle before timeout.
        clear_plan();
        plan_d[0] = TMO - 1; plan_l[0] = 4;
        run_batch(32'hFFFF_FFF8, 32'h0000_1000, 32'h0, 1, 1, 1);
        chk("t5_nwords", -1, 64'(obs_a0.size()), 64'd4);
        chk("t5_a0_0", -1, 64'(obs_a0[0]), 64'hFFFF_FFF8);
        chk("t5_a0_1", -1, 64'(obs_a0[1]), 64'hFFFF_FFFC);
        chk("t5_a0_2", -1, 64'(obs_a0[2]), 64'h0);
        chk("t5_a0_3", -1, 64'(obs_a0[3]), 64'h4);

        // Reset pulsed in the middle of a run.
        @(posedge Clk); #1;
        Computation_Start = 1'b1; Cfg_Iter = 16'd2; Cfg_Base = {32'h300, 32'h400};
        Cfg_Stride = 32'h10; Array_Busy = 1'b0;
        @(posedge Clk); #1; Array_Busy = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("t6_in_run", -1, 64'(Port_En), 64'(2'b11));
        Resetn = 1'b0;
        #1;
        Computation_Start = 1'b0; Array_Busy = 1'b0;
        chk("t6_port_rst", -1, 64'(Port_Rst), 64'(2'b11));
        chk("t6_outputs", -1, {Port_Addr[31:0], 8'(Port_Wen), 2'(Port_En), Array_Start,
                               Computation_Done, Error, 16'(Iter_Cnt)}, 64'h0);
        chk("t6_addr_hi", -1, 64'(Port_Addr[63:32]), 64'h0);
        @(negedge Clk);
        Resetn = 1'b1;
        prev_iter = 0;
        prev_err  = 1'b0;
        clear_plan();
        plan_d[0] = 0; plan_l[0] = 2;
        run_batch(32'h500, 32'h600, 32'h8, 1, 1, 0);
        chk("t6_fresh_start", -1, 64'(obs_st.size()), 64'd1);
        chk("t6_fresh_addr", -1, 64'(obs_a0[0]), 64'h500);

        // Randomized batches.
        for (int r = 0; r < 40; r++) begin
            int n;
            logic [31:0] b0, b1;
            clear_plan();
            n = $urandom_range(0, 4);
            for (int j = 0; j < n; j++) begin
                plan_to[j] = ($urandom_range(0, 9) == 0);
                plan_d[j]  = $urandom_range(0, TMO - 1);
                plan_l[j]  = $urandom_range(1, 8);
            end
            b0 = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 + 32'($urandom_range(0, 7) * 4)) : $urandom;
            b1 = $urandom;
            run_batch(b0, b1, $urandom, n, $urandom_range(1, 5), $urandom_range(0, 8) - 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
